xtea_arb: RTL and testbench
===========================

XTEA_ARB -- requirements
Module: xtea_arb

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 8'd160, watchdog limit in clk cycles, used only with XTEA_ARB_TIMEOUT_EN, legal range 100..255.
REQ-002 SHALL have ports, one per line: name direction width meaning.
- clk  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- reqN_valid_i  in  1  request N valid (N=0,1).
- reqN_ready_o  out  1  request N accepted this cycle when valid high.
- reqN_data_i  in  64  request N block.
- reqN_key_i  in  128  request N key.
- reqN_decrypt_i  in  1  request N mode: 0 encrypt, 1 decrypt.
- rspN_valid_o  out  1  one-cycle response pulse for requester N.
- rsp_data_o  out  64  result, shared by both requesters.
- rsp_err_o  out  1  response is a timeout, data invalid.
- core_valid_o  out  1  core valid_i drive.
- core_en_o  out  1  core en_i drive.
- core_data_o  out  64  core data_i.
- core_key_o  out  128  core key.
- core_decrypt_o  out  1  core decrypt_i.
- core_valid_i  in  1  core valid_o.
- core_result_i  in  64  core result_o.
- core_abort_o  out  1  one-cycle pulse, ORed into core reset by integrator.

Function
REQ-003 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; at most one operation outstanding.
REQ-004 IDLE: reqN_ready_o SHALL be combinational = (state==IDLE) & grant==N; all other states, both readies 0.
REQ-005 Grant SHALL be round-robin: both valid -> requester not served last; one valid -> that one; last-served pointer resets to 1, so req0 wins the first tie.
REQ-006 On handshake SHALL register data, key, decrypt and granted index, and go to ISSUE.
REQ-007 ISSUE SHALL last exactly 1 cycle with core_valid_o=core_en_o=1 and core_data_o/key_o/decrypt_o holding captured operands; these outputs SHALL stay stable from ISSUE until RESP ends; core_valid_o/en_o SHALL be 0 in all other states.
REQ-008 WAIT SHALL hold until core_valid_i=1, then register core_result_i into rsp_data_o and go to RESP.
REQ-009 RESP SHALL last 1 cycle: rspN_valid_o=1 for captured index only, rsp_err_o per REQ-014, update last-served pointer; no new handshake in RESP.
REQ-010 rsp_data_o SHALL hold its value until the next response; rspN_valid_o SHALL never be high for both N.
REQ-011 core_valid_i outside WAIT SHALL be ignored.
REQ-012 Overhead: accept-to-ISSUE 1 cycle; core_valid_i-to-rsp pulse 1 cycle; back-to-back throughput one op per (core latency + 3) cycles.
REQ-013 Requesters SHALL hold valid and operands until ready; dropping valid before ready SHALL cancel the request without side effects.

Reset
REQ-014 On rst_i, asynchronously: state IDLE, all rsp*, core_* outputs 0, rsp_data_o 0, rsp_err_o 0, last-served 1, watchdog 0; reset mid-operation SHALL discard the operation with no response pulse.
REQ-015 First handshake possible in the first clk edge after rst_i deasserts.

Configuration
REQ-016 Macro XTEA_ARB_TIMEOUT_EN defined: 8-bit watchdog cleared on ISSUE, incremented each WAIT cycle; on reaching TIMEOUT_CYCLES without core_valid_i SHALL pulse core_abort_o 1 cycle, go to RESP with rsp_err_o=1 and rsp_data_o=0; core_valid_i in the same cycle as the limit SHALL win (normal response).
REQ-017 Macro undefined: no watchdog logic, core_abort_o tied 0, rsp_err_o tied 0, WAIT unbounded.

Verification
REQ-018 Bench SHALL cover:
- req0 encrypt, key 0, data 0 -> rsp0_valid_o pulse, rsp_data_o=64'hDEE9D4D8F7131ED9, rsp_err_o=0.
- req1 decrypt, key 0, data 64'hDEE9D4D8F7131ED9 -> rsp1_valid_o, rsp_data_o=0.
- both valid from reset, continuously -> grants 0,1,0,1; every ready one cycle, each response to correct N.
- rst_i asserted in WAIT -> no rsp pulse; next req0 completes correctly.
- TIMEOUT_EN, stub core never responds -> after 160 WAIT cycles core_abort_o and rsp0_valid_o pulse with rsp_err_o=1, rsp_data_o=0.
- spurious core_valid_i in IDLE -> no response, state unchanged.

Source files
------------

// File: rtl/xtea_arb.sv
// Two-requester round-robin front end for a single XTEA core, one operation in flight.
// Define XTEA_ARB_TIMEOUT_EN to add the WAIT-state watchdog that aborts a hung core.
module xtea_arb #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd160
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         req0_valid_i,
  output logic         req0_ready_o,
  input  logic [63:0]  req0_data_i,
  input  logic [127:0] req0_key_i,
  input  logic         req0_decrypt_i,
  input  logic         req1_valid_i,
  output logic         req1_ready_o,
  input  logic [63:0]  req1_data_i,
  input  logic [127:0] req1_key_i,
  input  logic         req1_decrypt_i,
  output logic         rsp0_valid_o,
  output logic         rsp1_valid_o,
  output logic [63:0]  rsp_data_o,
  output logic         rsp_err_o,
  output logic         core_valid_o,
  output logic         core_en_o,
  output logic [63:0]  core_data_o,
  output logic [127:0] core_key_o,
  output logic         core_decrypt_o,
  input  logic         core_valid_i,
  input  logic [63:0]  core_result_i,
  output logic         core_abort_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e state_q;
  logic   last_q;
  logic   idx_q;
  logic   grant;
  logic   hs;

  // Tie goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid_i && req1_valid_i) grant = ~last_q;
    else if (req1_valid_i)            grant = 1'b1;
  end

  assign req0_ready_o = (state_q == StIdle) && !grant;
  assign req1_ready_o = (state_q == StIdle) && grant;
  assign hs = (req0_ready_o && req0_valid_i) || (req1_ready_o && req1_valid_i);

`ifdef XTEA_ARB_TIMEOUT_EN
  logic [7:0] wdog_q;
  logic       abort_q;
  logic       err_q;
  logic       timeout;

  assign timeout      = (wdog_q + 8'd1) == TIMEOUT_CYCLES;
  assign core_abort_o = abort_q;
  assign rsp_err_o    = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign core_abort_o   = 1'b0;
  assign rsp_err_o      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      last_q         <= 1'b1;
      idx_q          <= 1'b0;
      rsp0_valid_o   <= 1'b0;
      rsp1_valid_o   <= 1'b0;
      rsp_data_o     <= '0;
      core_valid_o   <= 1'b0;
      core_en_o      <= 1'b0;
      core_data_o    <= '0;
      core_key_o     <= '0;
      core_decrypt_o <= 1'b0;
`ifdef XTEA_ARB_TIMEOUT_EN
      wdog_q         <= '0;
      abort_q        <= 1'b0;
      err_q          <= 1'b0;
`endif
    end else begin
      core_valid_o <= 1'b0;
      core_en_o    <= 1'b0;
      rsp0_valid_o <= 1'b0;
      rsp1_valid_o <= 1'b0;
`ifdef XTEA_ARB_TIMEOUT_EN
      abort_q      <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (hs) begin
            idx_q          <= grant;
            core_data_o    <= grant ? req1_data_i : req0_data_i;
            core_key_o     <= grant ? req1_key_i : req0_key_i;
            core_decrypt_o <= grant ? req1_decrypt_i : req0_decrypt_i;
            core_valid_o   <= 1'b1;
            core_en_o      <= 1'b1;
            state_q        <= StIssue;
          end
        end
        StIssue: begin
`ifdef XTEA_ARB_TIMEOUT_EN
          wdog_q  <= '0;
`endif
          state_q <= StWait;
        end
        StWait: begin
          // A core response in the limit cycle still counts as a normal completion.
          if (core_valid_i) begin
            rsp_data_o   <= core_result_i;
            rsp0_valid_o <= ~idx_q;
            rsp1_valid_o <= idx_q;
`ifdef XTEA_ARB_TIMEOUT_EN
            err_q        <= 1'b0;
`endif
            state_q      <= StResp;
          end
`ifdef XTEA_ARB_TIMEOUT_EN
          else if (timeout) begin
            rsp_data_o   <= '0;
            rsp0_valid_o <= ~idx_q;
            rsp1_valid_o <= idx_q;
            err_q        <= 1'b1;
            abort_q      <= 1'b1;
            state_q      <= StResp;
          end else begin
            wdog_q <= wdog_q + 8'd1;
          end
`endif
        end
        StResp: begin
          last_q  <= idx_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_xtea_arb.sv
// Self-checking bench for xtea_arb with a behavioural XTEA stub core and a response scoreboard.
// Define XTEA_ARB_TIMEOUT_EN at compile time to exercise the watchdog path.
module tb_xtea_arb;

  localparam int StubLat = 3;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic         req0_ready_o, req1_ready_o;
  logic [63:0]  req0_data_i = '0, req1_data_i = '0;
  logic [127:0] req0_key_i = '0, req1_key_i = '0;
  logic         req0_decrypt_i = 1'b0, req1_decrypt_i = 1'b0;
  logic         rsp0_valid_o, rsp1_valid_o;
  logic [63:0]  rsp_data_o;
  logic         rsp_err_o;
  logic         core_valid_o, core_en_o;
  logic [63:0]  core_data_o;
  logic [127:0] core_key_o;
  logic         core_decrypt_o;
  logic         core_valid_i;
  logic [63:0]  core_result_i;
  logic         core_abort_o;

  int tests_run = 0;
  int fails = 0;

  typedef struct packed {
    logic        idx;
    logic [63:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];
  logic [63:0] last_rsp = '0;

  always #5 clk = ~clk;

  xtea_arb dut (
    .clk(clk), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_data_i(req0_data_i),
    .req0_key_i(req0_key_i), .req0_decrypt_i(req0_decrypt_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_data_i(req1_data_i),
    .req1_key_i(req1_key_i), .req1_decrypt_i(req1_decrypt_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp1_valid_o(rsp1_valid_o), .rsp_data_o(rsp_data_o),
    .rsp_err_o(rsp_err_o), .core_valid_o(core_valid_o), .core_en_o(core_en_o),
    .core_data_o(core_data_o), .core_key_o(core_key_o), .core_decrypt_o(core_decrypt_o),
    .core_valid_i(core_valid_i), .core_result_i(core_result_i), .core_abort_o(core_abort_o)
  );

  function automatic logic [63:0] xtea(input logic [63:0] d, input logic [127:0] k,
                                       input logic dec);
    logic [31:0] v0, v1, sum;
    logic [31:0] kw[4];
    kw[0] = k[127:96]; kw[1] = k[95:64]; kw[2] = k[63:32]; kw[3] = k[31:0];
    v0 = d[63:32];
    v1 = d[31:0];
    if (!dec) begin
      sum = 32'h0;
      for (int r = 0; r < 32; r++) begin
        v0  = v0 + ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + kw[sum[1:0]]));
        sum = sum + 32'h9E3779B9;
        v1  = v1 + ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + kw[sum[12:11]]));
      end
    end else begin
      sum = 32'hC6EF3720;
      for (int r = 0; r < 32; r++) begin
        v1  = v1 - ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + kw[sum[12:11]]));
        sum = sum - 32'h9E3779B9;
        v0  = v0 - ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + kw[sum[1:0]]));
      end
    end
    return {v0, v1};
  endfunction

  // Stub core: fixed latency, can be muted to model a hung core, cleared by abort/reset.
  logic        stub_mute = 1'b0;
  logic        stub_pend, stub_vld;
  int          stub_cnt;
  logic [63:0] stub_res, stub_out;
  logic        spur_v = 1'b0;
  logic [63:0] spur_d = '0;

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      stub_pend <= 1'b0; stub_vld <= 1'b0; stub_cnt <= 0; stub_res <= '0; stub_out <= '0;
    end else begin
      stub_vld <= 1'b0;
      if (core_abort_o) stub_pend <= 1'b0;
      else if (core_valid_o && core_en_o) begin
        stub_pend <= 1'b1;
        stub_cnt  <= StubLat;
        stub_res  <= xtea(core_data_o, core_key_o, core_decrypt_o);
      end else if (stub_pend) begin
        if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
        else if (!stub_mute) begin
          stub_vld  <= 1'b1;
          stub_out  <= stub_res;
          stub_pend <= 1'b0;
        end
      end
    end
  end

  assign core_valid_i  = stub_vld | spur_v;
  assign core_result_i = spur_v ? spur_d : stub_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request and pushes its expected response on acceptance; returns at accept+1.
  task automatic drive_req(input bit n, input logic dec, input logic [127:0] k,
                           input logic [63:0] d, input logic [63:0] exp_d, output bit ok);
    ok = 1'b0;
    tick();
    if (!n) begin
      req0_valid_i = 1'b1; req0_decrypt_i = dec; req0_key_i = k; req0_data_i = d;
    end else begin
      req1_valid_i = 1'b1; req1_decrypt_i = dec; req1_key_i = k; req1_data_i = d;
    end
    #1;
    for (int i = 0; i < 100 && !ok; i++) begin
      if ((!n && req0_ready_o) || (n && req1_ready_o)) begin
        ok = 1'b1;
        sb.push_back('{idx: n, data: exp_d, err: 1'b0});
      end
      tick();
    end
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output bit seen, output logic r0, output logic r1,
                          output logic [63:0] d, output logic e, output logic a);
    seen = 1'b0; r0 = 1'b0; r1 = 1'b0; d = '0; e = 1'b0; a = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (rsp0_valid_o || rsp1_valid_o) begin
        seen = 1'b1; r0 = rsp0_valid_o; r1 = rsp1_valid_o; d = rsp_data_o;
        e = rsp_err_o; a = core_abort_o;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    tests_run++;
    if ({rsp0_valid_o, rsp1_valid_o, rsp_err_o, core_valid_o, core_en_o, core_abort_o} !== 6'b0)
    begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {rsp0_valid_o, rsp1_valid_o, rsp_err_o, core_valid_o, core_en_o, core_abort_o});
    end
    tests_run++;
    if (rsp_data_o !== 64'h0 || core_data_o !== 64'h0 || core_key_o !== 128'h0) begin
      fails++;
      $display("FAIL reset_data: rsp %h core %h key %h want zeros", rsp_data_o, core_data_o,
               core_key_o);
    end
    tests_run++;
    if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
      fails++;
      $display("FAIL reset_ready: got %b want 10", {req0_ready_o, req1_ready_o});
    end
  endtask

  task automatic check_one(input string name, input bit issue_chk);
    bit seen, ok;
    logic r0, r1, e, a;
    logic [63:0] d;
    exp_t x;
    if (issue_chk) begin
      tests_run++;
      if ({core_valid_o, core_en_o} !== 2'b11) begin
        fails++;
        $display("FAIL %s_issue: core valid/en %b want 11", name, {core_valid_o, core_en_o});
      end
    end
    wait_rsp(50, seen, r0, r1, d, e, a);
    tests_run++;
    if (!seen || sb.size() == 0) begin
      fails++;
      $display("FAIL %s_rsp: seen %0d queued %0d want a response", name, seen, sb.size());
      sb.delete();
    end else begin
      x = sb.pop_front();
      last_rsp = x.data;
      if ({r0, r1, d, e} !== {~x.idx, x.idx, x.data, x.err}) begin
        fails++;
        $display("FAIL %s_rsp: got r0=%b r1=%b d=%h err=%b want r0=%b r1=%b d=%h err=%b",
                 name, r0, r1, d, e, ~x.idx, x.idx, x.data, x.err);
      end
    end
  endtask

  task automatic test_encrypt();
    bit ok;
    drive_req(1'b0, 1'b0, 128'h0, 64'h0, 64'hDEE9D4D8F7131ED9, ok);
    check_one("encrypt0", ok);
    tick(); tick(); tick();
    tests_run++;
    if (rsp_data_o !== 64'hDEE9D4D8F7131ED9) begin
      fails++;
      $display("FAIL rsp_hold: got %h want %h", rsp_data_o, 64'hDEE9D4D8F7131ED9);
    end
  endtask

  task automatic test_decrypt();
    bit ok;
    drive_req(1'b1, 1'b1, 128'h0, 64'hDEE9D4D8F7131ED9, 64'h0, ok);
    check_one("decrypt1", ok);
  endtask

  task automatic test_back_to_back();
    logic [127:0] k0, k1;
    logic [63:0]  d0, d1;
    bit got;
    k0 = {$urandom, $urandom, $urandom, $urandom};
    k1 = {$urandom, $urandom, $urandom, $urandom};
    d0 = {$urandom, $urandom};
    d1 = {$urandom, $urandom};
    rst_i = 1'b1;
    tick();
    req0_valid_i = 1'b1; req0_key_i = k0; req0_data_i = d0; req0_decrypt_i = 1'b0;
    req1_valid_i = 1'b1; req1_key_i = k1; req1_data_i = d1; req1_decrypt_i = 1'b1;
    rst_i = 1'b0;
    #1;
    for (int n = 0; n < 4; n++) begin
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
        if (req0_ready_o || req1_ready_o) got = 1'b1;
        else tick();
      end
      tests_run++;
      if (!got || req1_ready_o !== n[0] || req0_ready_o !== ~n[0]) begin
        fails++;
        $display("FAIL b2b_grant%0d: ready0=%b ready1=%b want grant %0d", n, req0_ready_o,
                 req1_ready_o, n % 2);
      end
      sb.push_back('{idx: n[0], data: n[0] ? xtea(d1, k1, 1'b1) : xtea(d0, k0, 1'b0),
                     err: 1'b0});
      tick();
      tests_run++;
      if ({req0_ready_o, req1_ready_o} !== 2'b00) begin
        fails++;
        $display("FAIL b2b_ready_len%0d: got %b want 00", n, {req0_ready_o, req1_ready_o});
      end
      check_one("b2b", 1'b1);
      tick();
    end
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    bit ok, seen;
    logic r0, r1, e, a;
    logic [63:0] d, k;
    stub_mute = 1'b1;
    drive_req(1'b0, 1'b0, 128'h1234, 64'h55, xtea(64'h55, 128'h1234, 1'b0), ok);
    for (int i = 0; i < 6; i++) tick();
    rst_i = 1'b1;
    #1;
    tests_run++;
    if (rsp_data_o !== 64'h0 || core_data_o !== 64'h0 || {rsp0_valid_o, rsp1_valid_o} !== 2'b0)
    begin
      fails++;
      $display("FAIL rst_wait_clear: rsp %h core %h pulses %b want zeros", rsp_data_o,
               core_data_o, {rsp0_valid_o, rsp1_valid_o});
    end
    sb.delete();
    last_rsp = '0;
    tick();
    rst_i = 1'b0;
    stub_mute = 1'b0;
    wait_rsp(15, seen, r0, r1, d, e, a);
    tests_run++;
    if (seen) begin
      fails++;
      $display("FAIL rst_wait_nopulse: got pulse r0=%b r1=%b want none", r0, r1);
    end
    k = {$urandom, $urandom};
    drive_req(1'b0, 1'b0, {k, k}, 64'hCAFE, xtea(64'hCAFE, {k, k}, 1'b0), ok);
    check_one("after_rst", ok);
  endtask

`ifdef XTEA_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok, seen;
    int n;
    stub_mute = 1'b1;
    drive_req(1'b0, 1'b0, 128'h0, 64'h0, 64'h0, ok);
    sb.delete();
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      n++;
      if (rsp0_valid_o || rsp1_valid_o || core_abort_o) seen = 1'b1;
    end
    tests_run++;
    if (!seen || n != 161) begin
      fails++;
      $display("FAIL timeout_cycles: seen %0d after %0d cycles want 161", seen, n);
    end
    tests_run++;
    if ({core_abort_o, rsp0_valid_o, rsp1_valid_o, rsp_err_o} !== 4'b1101 || rsp_data_o !== '0)
    begin
      fails++;
      $display("FAIL timeout_rsp: abort/r0/r1/err %b data %h want 1101 data 0",
               {core_abort_o, rsp0_valid_o, rsp1_valid_o, rsp_err_o}, rsp_data_o);
    end
    last_rsp = '0;
    tick();
    tests_run++;
    if (core_abort_o !== 1'b0) begin
      fails++;
      $display("FAIL timeout_abort_len: abort %b want 0", core_abort_o);
    end
    stub_mute = 1'b0;
  endtask
`else
  task automatic test_timeout();
    bit ok;
    int bad;
    stub_mute = 1'b1;
    drive_req(1'b0, 1'b1, 128'h77, 64'h99, xtea(64'h99, 128'h77, 1'b1), ok);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (rsp0_valid_o || rsp1_valid_o || core_abort_o || rsp_err_o) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      fails++;
      $display("FAIL stall_quiet: %0d active cycles want 0", bad);
    end
    stub_mute = 1'b0;
    check_one("stall_release", 1'b0);
  endtask
`endif

  task automatic test_spurious();
    bit seen;
    logic r0, r1, e, a;
    logic [63:0] d;
    tick();
    spur_d = 64'hBADC0FFEE0DDF00D;
    spur_v = 1'b1;
    tick();
    spur_v = 1'b0;
    wait_rsp(6, seen, r0, r1, d, e, a);
    tests_run++;
    if (seen || rsp_data_o !== last_rsp) begin
      fails++;
      $display("FAIL spurious: pulse %0d data %h want no pulse data %h", seen, rsp_data_o,
               last_rsp);
    end
    tests_run++;
    if ({req0_ready_o, core_valid_o} !== 2'b10) begin
      fails++;
      $display("FAIL spurious_idle: ready0/core_valid %b want 10", {req0_ready_o, core_valid_o});
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_spurious();
    test_back_to_back();
    test_reset_in_wait();
    test_timeout();
    test_spurious();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
